// File: rtl/hex_display_mux.sv
// hex_display_mux: time-multiplexed driver for a bank of 7-segment digits.
// A shadow register holds the packed hex value and decimal points. One digit
// is shown per slot of SCAN_DIV cycles, and the first GUARD cycles of each
// slot keep all anodes off so the previous digit does not ghost onto the next.
// Segment and anode outputs are registered, with one cycle of latency from the
// scan state. The optional feature is selected by the macro
// LEADING_ZERO_BLANK_EN: when it is defined, leading zero digits are blanked.
module hex_display_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int GUARD          = 2,
  parameter int ACTIVE_LOW_SEG = 0,
  parameter int ACTIVE_LOW_AN  = 0,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int PRE_W = $clog2(SCAN_DIV)
) (
  input  logic                    Clk,
  input  logic                    nReset,
  input  logic                    Enable,
  input  logic                    Load,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic [NUM_DIGITS-1:0]   DPIn,
  output logic [7:0]              SSeg,
  output logic [NUM_DIGITS-1:0]   Anode,
  output logic [IDX_W-1:0]        DigitIdx,
  output logic                    FrameDone
);

  // Hex nibble to GFEDCBA segment pattern (bit0 = segment A).
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Scan state.
  logic [PRE_W-1:0]        prescale_reg, prescale_next;
  logic [IDX_W-1:0]        digit_idx_reg, digit_idx_next;

  // Shadow copy of the display data.
  logic [4*NUM_DIGITS-1:0] value_sh_reg;
  logic [NUM_DIGITS-1:0]   dp_sh_reg;

  // Output registers. These are held active-high; polarity is applied at the pins.
  logic [NUM_DIGITS-1:0]   anode_reg, anode_next;
  logic [7:0]              sseg_reg, sseg_next;
  logic                    frame_done_reg, frame_done_next;

  // Decode helpers.
  logic                    last_cycle;
  logic                    last_digit;
  logic                    past_guard;
  logic                    show;
  logic [NUM_DIGITS-1:0]   blank;
  logic [7:0]              seg_digit [NUM_DIGITS];
  logic [7:0]              seg_sel;

  assign last_cycle = (prescale_reg == PRE_W'(SCAN_DIV - 1));
  assign last_digit = (digit_idx_reg == IDX_W'(NUM_DIGITS - 1));

  // With no guard band every slot cycle is visible. The compare is kept out of
  // the GUARD == 0 build because an unsigned >= 0 test is always true.
  generate
    if (GUARD == 0) begin : g_no_guard
      assign past_guard = 1'b1;
    end else begin : g_guard
      assign past_guard = (prescale_reg >= PRE_W'(GUARD));
    end
  endgenerate

  assign show = Enable && past_guard;

  // Leading-zero blanking looks at the shadow copy, so it has the same latency
  // as the segment data. Digit 0 is always shown. A set decimal point keeps a
  // zero digit visible.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
`ifdef LEADING_ZERO_BLANK_EN
      if (gi == 0) begin : g_first
        assign blank[gi] = 1'b0;
      end else begin : g_upper
        assign blank[gi] = (value_sh_reg[4*NUM_DIGITS-1:4*gi] == '0) && !dp_sh_reg[gi];
      end
`else
      assign blank[gi] = 1'b0;
`endif
    end
  endgenerate

  // Segment pattern for each digit of the shadow. A blanked digit drives no
  // segments, but its anode is still driven.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_decode
      assign seg_digit[gi] = blank[gi] ? 8'h00
                           : {dp_sh_reg[gi], hex_to_seg(value_sh_reg[4*gi +: 4])};
    end
  endgenerate

  // Select the segment pattern of the digit in the current slot. Index codes
  // above NUM_DIGITS-1 are never reached, so they fall through to dark.
  always_comb begin
    seg_sel = 8'h00;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx_reg == IDX_W'(i)) begin
        seg_sel = seg_digit[i];
      end
    end
  end

  // Next-state logic for the prescaler and digit index. Both hold while the
  // scan is disabled.
  always_comb begin
    prescale_next  = prescale_reg;
    digit_idx_next = digit_idx_reg;
    if (Enable) begin
      if (last_cycle) begin
        prescale_next  = '0;
        digit_idx_next = last_digit ? '0 : digit_idx_reg + IDX_W'(1);
      end else begin
        prescale_next  = prescale_reg + PRE_W'(1);
      end
    end
  end

  // Next values of the output registers, computed from the scan state before
  // the clock edge.
  always_comb begin
    anode_next      = '0;
    sseg_next       = 8'h00;
    frame_done_next = Enable && last_cycle && last_digit;
    if (show) begin
      sseg_next = seg_sel;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        anode_next[i] = (digit_idx_reg == IDX_W'(i));
      end
    end
  end

  // Scan counter registers.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      prescale_reg  <= '0;
      digit_idx_reg <= '0;
    end else begin
      prescale_reg  <= prescale_next;
      digit_idx_reg <= digit_idx_next;
    end
  end

  // Shadow capture. Load works whether or not the scan is enabled.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      value_sh_reg <= '0;
      dp_sh_reg    <= '0;
    end else if (Load) begin
      value_sh_reg <= Value;
      dp_sh_reg    <= DPIn;
    end
  end

  // Registered display outputs and the frame pulse.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      anode_reg      <= '0;
      sseg_reg       <= 8'h00;
      frame_done_reg <= 1'b0;
    end else begin
      anode_reg      <= anode_next;
      sseg_reg       <= sseg_next;
      frame_done_reg <= frame_done_next;
    end
  end

  // Pin polarity. The inversion is by a constant, so the pins stay registered.
  assign SSeg      = (ACTIVE_LOW_SEG != 0) ? ~sseg_reg  : sseg_reg;
  assign Anode     = (ACTIVE_LOW_AN  != 0) ? ~anode_reg : anode_reg;
  assign DigitIdx  = digit_idx_reg;
  assign FrameDone = frame_done_reg;

endmodule

// File: tb/tb_hex_display_mux.sv
// tb_hex_display_mux: randomized and directed stimulus for hex_display_mux
// (4 digits, 8-cycle slots, 2-cycle guard, active-high outputs). A behavioural
// model of the display, built from slot arithmetic and a decode table, predicts
// every output on every cycle.
module tb_hex_display_mux;

  localparam int ND    = 4;
  localparam int DIV   = 8;
  localparam int GUARD = 2;

  logic        Clk;
  logic        nReset;
  logic        Enable;
  logic        Load;
  logic [15:0] Value;
  logic [3:0]  DPIn;
  logic [7:0]  SSeg;
  logic [3:0]  Anode;
  logic [1:0]  DigitIdx;
  logic        FrameDone;

  hex_display_mux #(
    .NUM_DIGITS(ND), .SCAN_DIV(DIV), .GUARD(GUARD),
    .ACTIVE_LOW_SEG(0), .ACTIVE_LOW_AN(0)
  ) dut (
    .Clk(Clk), .nReset(nReset), .Enable(Enable), .Load(Load),
    .Value(Value), .DPIn(DPIn), .SSeg(SSeg), .Anode(Anode),
    .DigitIdx(DigitIdx), .FrameDone(FrameDone)
  );

  // 10 ns clock period.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_vec  = 0;
  int n_miss = 0;
  int n_cyc  = 0;

  // Reference model state.
  int         m_p;
  int         m_d;
  int         m_nib [ND];
  int         m_dp  [ND];
  logic [3:0] e_an;
  logic [7:0] e_seg;
  logic       e_fd;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Single comparison point.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, n_cyc);
    end
  endtask

  task automatic model_reset();
    m_p = 0;
    m_d = 0;
    for (int i = 0; i < ND; i++) begin
      m_nib[i] = 0;
      m_dp[i]  = 0;
    end
    e_an  = '0;
    e_seg = '0;
    e_fd  = 1'b0;
  endtask

  // Advance the model by one clock edge with the given inputs applied.
  task automatic model_edge(input logic en, input logic ld,
                            input logic [15:0] v, input logic [3:0] dp);
    logic blank;
    e_an  = '0;
    e_seg = '0;
    if (en && m_p >= GUARD) begin
      e_an  = 4'(1 << m_d);
      blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      blank = (m_d > 0) && (m_dp[m_d] == 0);
      for (int j = m_d; j < ND; j++) if (m_nib[j] != 0) blank = 1'b0;
`endif
      if (!blank) e_seg = {m_dp[m_d][0], seg_tab[m_nib[m_d]]};
    end
    e_fd = en && (m_p == DIV - 1) && (m_d == ND - 1);
    if (ld) begin
      for (int i = 0; i < ND; i++) begin
        m_nib[i] = int'(v[4*i +: 4]);
        m_dp[i]  = int'(dp[i]);
      end
    end
    if (en) begin
      if (m_p == DIV - 1) begin
        m_p = 0;
        m_d = (m_d + 1) % ND;
      end else begin
        m_p = m_p + 1;
      end
    end
  endtask

  // One clock cycle: drive inputs at edge+1, update the model at the edge,
  // then compare at edge+1.
  task automatic cycle(input logic en, input logic ld,
                       input logic [15:0] v, input logic [3:0] dp);
    Enable = en;
    Load   = ld;
    Value  = v;
    DPIn   = dp;
    @(posedge Clk);
    model_edge(en, ld, v, dp);
    #1;
    n_cyc++;
    chk("anode", 32'(Anode), 32'(e_an));
    chk("sseg", 32'(SSeg), 32'(e_seg));
    chk("digit_idx", 32'(DigitIdx), 32'(m_d));
    chk("frame_done", 32'(FrameDone), 32'(e_fd));
    $display("cyc %0d en=%b ld=%b val=%h dp=%b | an=%b seg=%h idx=%0d fd=%b",
             n_cyc, en, ld, v, dp, Anode, SSeg, DigitIdx, FrameDone);
  endtask

  // Assert reset between clock edges. The outputs must clear at once, without
  // waiting for an edge.
  task automatic mid_reset();
    #2;
    nReset = 1'b0;
    #1;
    chk("rst_anode", 32'(Anode), 32'h0);
    chk("rst_sseg", 32'(SSeg), 32'h0);
    chk("rst_fd", 32'(FrameDone), 32'h0);
    chk("rst_idx", 32'(DigitIdx), 32'h0);
    model_reset();
    @(posedge Clk);
    #1;
    nReset = 1'b1;
    $display("reset pulse applied at cycle %0d", n_cyc);
  endtask

  // Hold the current inputs until the model reaches the requested slot
  // position. A run past the cycle bound is counted as a miscompare.
  task automatic run_until(input int p, input int d, input logic [15:0] v, input logic [3:0] dp);
    int guard_cnt;
    guard_cnt = 0;
    while (!(m_p == p && (d < 0 || m_d == d)) && guard_cnt < 64) begin
      cycle(1'b1, 1'b0, v, dp);
      guard_cnt++;
    end
    chk("reach_slot_pos", 32'(guard_cnt < 64), 32'h1);
  endtask

  logic [15:0] rv;
  logic [3:0]  rdp;
  logic        ren;
  logic        rld;

  initial begin
    nReset = 1'b0;
    Enable = 1'b0;
    Load   = 1'b0;
    Value  = '0;
    DPIn   = '0;
    model_reset();
    #1;
    chk("init_anode", 32'(Anode), 32'h0);
    chk("init_sseg", 32'(SSeg), 32'h0);
    chk("init_idx", 32'(DigitIdx), 32'h0);
    chk("init_fd", 32'(FrameDone), 32'h0);
    @(posedge Clk);
    #1;
    nReset = 1'b1;

    // Load 1A3F with the DP on digit 2, then scan a little over two frames.
    cycle(1'b0, 1'b1, 16'h1A3F, 4'b0100);
    for (int i = 0; i < 70; i++) cycle(1'b1, 1'b0, 16'h0000, 4'b0000);

    // Reload on the edge where digit 0 advances to digit 1.
    run_until(DIV - 1, 0, 16'h0000, 4'b0000);
    cycle(1'b1, 1'b1, 16'h0008, 4'b0000);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 16'h0000, 4'b0000);

    // Freeze the scan at prescale 5 for 10 cycles, then resume.
    run_until(5, -1, 16'h0000, 4'b0000);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 16'h0000, 4'b0000);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 16'h0000, 4'b0000);

    // Leading zeros: 0042 with no decimal points.
    cycle(1'b1, 1'b1, 16'h0042, 4'b0000);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 16'h0000, 4'b0000);

    // Reset in the middle of a scan.
    mid_reset();
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 16'h0000, 4'b0000);

    // Randomized traffic.
    for (int i = 0; i < 700; i++) begin
      ren = ($urandom_range(0, 9) != 0);
      rld = ($urandom_range(0, 19) == 0);
      rv  = 16'($urandom);
      rv  = rv >> (4 * $urandom_range(0, 4));
      rdp = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
      cycle(ren, rld, rv, rdp);
      if ($urandom_range(0, 249) == 0) mid_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
